// File: rtl/lsu_if.sv
// Request/response and physical-memory signals of the load/store unit.
// The lsu side uses the slave modport; the execute stage or bench uses master.
interface lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_op;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_op, in_wen, out_ready, mem_rdata,
    output in_ready, out_valid, out_rdata, out_err,
    output mem_valid, mem_raddr, mem_waddr, mem_wdata, mem_wmask, mem_wen
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_op, in_wen, out_ready, mem_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
    input  mem_valid, mem_raddr, mem_waddr, mem_wdata, mem_wmask, mem_wen
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, alignment/opcode checks, a single
// word-aligned memory access after LATENCY cycles, then an extended response.
module lsu #(
  parameter int unsigned LATENCY = 1
) (
  input logic  clock,
  input logic  reset,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  op_q;
  logic        wen_q;
  logic        err_q;
  logic [3:0]  cnt_q;

  logic [1:0]  off;
  logic        access;
  logic        req_bad;
  logic [31:0] word;
  logic [31:0] load_val;
  logic [3:0]  lane_mask;

  assign off    = addr_q[1:0];
  assign access = (state_q == StWait) && (cnt_q == 4'd0);

  // Legality of the incoming request, judged on its own address offset.
  always_comb begin
    req_bad = 1'b1;
    if (bus.in_wen) begin
      case (bus.in_op)
        3'b000:  req_bad = 1'b0;
        3'b001:  req_bad = bus.in_addr[0];
        3'b010:  req_bad = (bus.in_addr[1:0] != 2'b00);
        default: req_bad = 1'b1;
      endcase
    end else begin
      case (bus.in_op)
        3'b000, 3'b100: req_bad = 1'b0;
        3'b001, 3'b101: req_bad = bus.in_addr[0];
        3'b010:         req_bad = (bus.in_addr[1:0] != 2'b00);
        default:        req_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    word     = bus.mem_rdata >> {off, 3'b000};
    load_val = word;
    case (op_q)
      3'b000:  load_val = {{24{word[7]}}, word[7:0]};
      3'b100:  load_val = {24'h0, word[7:0]};
      3'b001:  load_val = {{16{word[15]}}, word[15:0]};
      3'b101:  load_val = {16'h0, word[15:0]};
      default: load_val = word;
    endcase
  end

  always_comb begin
    case (op_q[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            op_q    <= bus.in_op;
            wen_q   <= bus.in_wen;
            err_q   <= req_bad;
            rdata_q <= '0;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= req_bad ? StDone : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= wen_q ? 32'h0 : load_val;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_rdata = rdata_q;
  assign bus.out_err   = err_q;
  assign bus.mem_valid = access;
  assign bus.mem_wen   = access && wen_q;
  assign bus.mem_raddr = {addr_q[31:2], 2'b00};
  assign bus.mem_waddr = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q << {off, 3'b000};
  assign bus.mem_wmask = (access && wen_q) ? {4'b0000, lane_mask} : 8'h00;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the physical-memory DPI block in the NPC core. It accepts one memory request at a time from the execute stage over a valid/ready handshake, and checks alignment and opcode legality. It drives a single-cycle, word-aligned access to physical memory after a programmable latency, then returns the aligned, sign- or zero-extended load data, or a store completion, over a second valid/ready handshake.

## Interface
- LATENCY, 1, cycles from request acceptance to the memory access cycle; legal range 1..15.

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents a request
- in_ready  out  1  LSU can accept a request (high only in IDLE)
- in_addr  in  32  byte address
- in_wdata  in  32  store data, right-justified
- in_op  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- in_wen  in  1  1 = store, 0 = load
- out_valid  out  1  response available
- out_ready  in  1  consumer accepts the response
- out_rdata  out  32  extended load data; 0 for stores and errors
- out_err  out  1  request was misaligned or illegal; no memory access made
- mem_valid  out  1  memory access strobe, exactly one cycle per legal request
- mem_raddr  out  32  word-aligned read address, {addr[31:2],2'b00}
- mem_waddr  out  32  word-aligned write address, same value as mem_raddr
- mem_wdata  out  32  store data shifted into byte lanes
- mem_wmask  out  8  byte-lane write mask; bits [7:4] always 0
- mem_wen  out  1  write enable; high only when mem_valid and the request is a store
- mem_rdata  in  32  word read from memory, valid combinationally while mem_valid

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch addr, wdata, op, wen, and set off=addr[1:0].
  - Request illegal or misaligned: latch out_err=1 and out_rdata=0, then go to DONE. No mem_valid is issued.
  - Otherwise: load counter with LATENCY-1, then go to WAIT.
- WAIT: the counter decrements each cycle. When counter==0, mem_valid=1 for that cycle only.
  - Load: capture the extended data into out_rdata.
  - Store: mem_wen=1, and out_rdata is set to 0.
  - Next state is DONE.
- DONE: out_valid=1, held with out_rdata and out_err stable until out_ready. On out_valid&out_ready, go to IDLE. A new request is only accepted in the following cycle.
- Illegal op:
  - Load: funct3 in {011,110,111}.
  - Store: funct3 not in {000,001,010}.
- Misaligned:
  - H/HU/SH with off[0]=1.
  - W/SW with off!=0.
- Store lanes:
  - mem_wdata = in_wdata << (8*off).
  - mem_wmask for SB = 0001<<off, for SH = 0011<<off, for SW = 1111.
- Load extract: w = mem_rdata >> (8*off).
  - B: sign-extend w[7:0]. BU: zero-extend w[7:0].
  - H: sign-extend w[15:0]. HU: zero-extend w[15:0].
  - W: w.
- Outside the access cycle: mem_wen=0 and mem_wmask=0. Addresses and wdata reflect the latched request.

## Timing
- Legal request accepted at edge N:
  - WAIT occupies cycles N+1..N+LATENCY.
  - mem_valid is high in cycle N+LATENCY.
  - out_valid is first high in cycle N+LATENCY+1.
- Error request accepted at edge N: out_valid is high in cycle N+1.
- Minimum request spacing is LATENCY+2 cycles when out_ready is held at 1.
- out_ready low in DONE: hold all outputs; no further memory access.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_rdata=0, out_err=0, mem_valid=0, mem_wen=0, mem_wmask=0, mem_raddr=mem_waddr=0, mem_wdata=0.
- Reset asserted in WAIT or DONE: abort in that cycle. No mem_valid is issued after the reset edge and no response is produced. IDLE follows.
- mem_rdata is sampled only in the mem_valid cycle. Its value in other cycles is ignored.

## Test plan
- LATENCY=1, memory word 0x8000_0000=0x1234_5678, LW at 0x8000_0000 -> mem_valid exactly one cycle with mem_raddr=0x8000_0000; next cycle out_valid=1, out_rdata=0x1234_5678, out_err=0.
- Same memory, LB at 0x8000_0003 then LBU at 0x8000_0003, with word 0x8012_3456 -> out_rdata=0xFFFF_FF80 and 0x0000_0080.
- SB data 0x0000_00AB at 0x8000_0002 -> mem_wen=1, mem_wmask=0x04, mem_wdata=0x00AB_0000, mem_waddr=0x8000_0000; response out_rdata=0, out_err=0.
- SH at 0x8000_0001 -> out_valid the cycle after acceptance, out_err=1, mem_valid never asserted; in_op=011 with in_wen=1 -> same error behaviour.
- LATENCY=3, out_ready held 0 for 5 cycles in DONE -> mem_valid high exactly once; out_valid, out_rdata and out_err stable; in_ready=0 throughout; return to IDLE one cycle after out_ready=1.
- LATENCY=3, reset asserted in the second WAIT cycle -> mem_valid never asserted, out_valid stays 0, in_ready=1 the cycle after reset releases.
